handshaking_slave: RTL and testbench
====================================

HANDSHAKING_SLAVE -- requirements
Module: handshaking_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, the receive-buffer depth in words; it must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, width 1: the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst, input, width 1: the reset, which is synchronous and active-low.
REQ-005 SHALL have port data_in, input, DATA_WIDTH: the payload from the master.
REQ-006 SHALL have port data_valid, input, width 1: the master asserts it when data_in holds a valid word.
REQ-007 SHALL have port data_ready, output, width 1: asserted when the slave can accept a word.
REQ-008 SHALL have port data_out, output, DATA_WIDTH: the head-of-buffer word for the downstream consumer.
REQ-009 SHALL have port out_valid, output, width 1: asserted when data_out holds a valid word.
REQ-010 SHALL have port out_ready, input, width 1: the downstream consumer asserts it when it can take data_out.
REQ-011 SHALL have port fill, output, width clog2(DEPTH)+1: the number of words currently buffered.
REQ-012 SHALL have port proto_err, output, width 1: a sticky flag for a master protocol violation.

Function
REQ-013 SHALL accept a word on a rising edge where data_valid=1 and data_ready=1, writing data_in to the tail of a DEPTH-entry circular buffer.
REQ-014 SHALL drive data_ready = (fill < DEPTH), decoded from registered state only, with no combinational path from data_valid.
REQ-015 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-016 SHALL operate first-word-fall-through: data_out = head entry and out_valid = (fill != 0). A word accepted at edge N is visible on data_out right after edge N.
REQ-017 SHALL leave fill unchanged on a simultaneous accept and pop, and SHALL update both pointers.
REQ-018 SHALL NOT accept when full, even if a pop occurs in the same cycle; data_ready rises in the cycle after the pop.
REQ-019 SHALL wrap read and write pointers modulo DEPTH and SHALL never overwrite unread data.
REQ-020 SHALL hold data_out stable while out_valid=1 and out_ready=0.
REQ-021 SHALL track master state in an FSM with three states:
- IDLE: data_valid=0.
- OFFER: data_valid=1 and data_ready=1 (accepted in this state).
- STALL: data_valid=1 and data_ready=0. The captured data_in is held for comparison.
REQ-022 SHALL use these FSM transitions:
- IDLE -> OFFER or STALL on data_valid=1, selected by data_ready.
- STALL -> OFFER when data_ready rises.
- OFFER -> IDLE, OFFER or STALL, evaluated the same way as from IDLE.
REQ-023 SHALL set proto_err when, in STALL, data_valid drops or data_in differs from the captured value. proto_err stays set until reset.
REQ-024 SHALL keep accepting and delivering data normally while proto_err=1.

Reset
REQ-025 SHALL, when rst=0 at a rising edge, clear the pointers, set fill=0, set out_valid=0, set data_ready=1 (registered state only), clear proto_err and set the FSM to IDLE.
REQ-026 SHALL force data_out to all-zero during and after reset until the first word is accepted.
REQ-027 SHALL discard all buffered words on a reset mid-transfer, with no partial word delivered afterwards.
REQ-028 SHALL ignore data_valid and out_ready on a cycle where rst=0.

Configuration
REQ-029 SHALL, when macro HANDSHAKING_SLAVE_COUNT_EN is defined:
- add output port rx_count, width 16, counting accepted words;
- reset rx_count to 0;
- wrap rx_count from 16'hFFFF to 16'h0000.
REQ-030 SHALL, when HANDSHAKING_SLAVE_COUNT_EN is undefined, omit the rx_count port and its counter, with all other behaviour identical.

Verification
REQ-031 Bench SHALL cover basic transfer: data_in=8'h96, data_valid=1 for one cycle, out_ready=1 -> data_out=8'h96 and out_valid=1 after the accept edge, popped next edge, fill returns to 0.
REQ-032 Bench SHALL cover fill and backpressure: out_ready=0, push 8'h01..8'h04 -> fill=4, data_ready=0. Then hold data_valid=1 with 8'h05 -> no accept and proto_err stays 0.
REQ-033 Bench SHALL cover drain order: from full, out_ready=1 -> data_out sequence 8'h01,8'h02,8'h03,8'h04. Pending 8'h05 is accepted one cycle after the first pop.
REQ-034 Bench SHALL cover simultaneous push and pop: with fill=2, push and pop in the same cycle -> fill stays 2 and order is preserved across pointer wrap for 10 words.
REQ-035 Bench SHALL cover protocol error: while stalled, change data_in 8'h96 -> 8'h69 -> proto_err=1 the next cycle and it remains 1 until rst=0.
REQ-036 Bench SHALL cover reset mid-operation: with fill=3, rst=0 for one edge -> fill=0, out_valid=0, data_ready=1, data_out=0. With COUNT_EN, rx_count=0.

Source files
------------

// File: rtl/handshaking_slave.sv
// handshaking_slave: valid/ready receiver with a first-word-fall-through
// circular buffer and a monitor that flags a master that withdraws or
// changes its word while it is being stalled.
// Optional feature: define HANDSHAKING_SLAVE_COUNT_EN to add the 16-bit
// rx_count output, which counts accepted words and wraps to zero.
module handshaking_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   proto_err
`ifdef HANDSHAKING_SLAVE_COUNT_EN
    ,
    output logic [15:0]            rx_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        STALL = 2'd2
    } masterState_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [AW:0]           fill_q, fill_d;
    masterState_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] held_q, held_d;
    logic                  err_q, err_d;
    logic                  push;
    logic                  pop;

    // Handshake decode and outputs come only from registered state, so
    // data_ready never depends combinationally on data_valid.
    always_comb begin
        data_ready = (fill_q < FULL_LEVEL);
        out_valid  = (fill_q != '0);
        data_out   = out_valid ? mem_q[rdPtr_q] : '0;
        fill       = fill_q;
        proto_err  = err_q;
        push       = data_valid & data_ready;
        pop        = out_valid & out_ready;
    end

    // Pointer and occupancy next-state; a full buffer refuses even if it pops.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        fill_d  = fill_q;
        if (push) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + (AW+1)'(1);
        end else if (!push && pop) begin
            fill_d = fill_q - (AW+1)'(1);
        end
    end

    // Master-tracking FSM: a stalled word must stay valid and unchanged.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        err_d   = err_q;
        if (state_q == STALL && (!data_valid || data_in != held_q)) begin
            err_d = 1'b1;
        end
        if (!data_valid) begin
            state_d = IDLE;
        end else if (data_ready) begin
            state_d = OFFER;
        end else begin
            state_d = STALL;
            held_d  = data_in;
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            fill_q  <= '0;
            state_q <= IDLE;
            held_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            held_q  <= held_d;
            err_q   <= err_d;
        end
    end

    // Buffer storage needs no reset: unread entries are masked by fill.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wrPtr_q] <= data_in;
        end
    end

`ifdef HANDSHAKING_SLAVE_COUNT_EN
    logic [15:0] count_q;

    // Accepted-word counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (push) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign rx_count = count_q;
`endif

endmodule

// File: tb/tb_handshaking_slave.sv
// Directed self-checking bench for handshaking_slave (DEPTH=4, 8-bit data).
module tb_handshaking_slave;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    fill;
    logic          proto_err;
`ifdef HANDSHAKING_SLAVE_COUNT_EN
    logic [15:0]   rx_count;
`endif

    int checks = 0;
    int errors = 0;

    handshaking_slave #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill       (fill),
        .proto_err  (proto_err)
`ifdef HANDSHAKING_SLAVE_COUNT_EN
        ,
        .rx_count   (rx_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; data_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        tick(); tick();
        checks++; if (fill !== 3'd0) begin errors++; $display("[TB] FAIL reset_fill got %0d exp 0", fill); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_data_ready got %b exp 1", data_ready); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data_out got %h exp 00", data_out); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_proto_err got %b exp 0", proto_err); end
        rst = 1'b1;
        tick();
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_data_out got %h exp 00", data_out); end
`ifdef HANDSHAKING_SLAVE_COUNT_EN
        checks++; if (rx_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_rx_count got %0d exp 0", rx_count); end
`endif
    endtask

    task automatic test_basic();
        out_ready = 1'b1; data_in = 8'h96; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid got %b exp 1", out_valid); end
        checks++; if (data_out !== 8'h96) begin errors++; $display("[TB] FAIL basic_data_out got %h exp 96", data_out); end
        checks++; if (fill !== 3'd1) begin errors++; $display("[TB] FAIL basic_fill got %0d exp 1", fill); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pop_out_valid got %b exp 0", out_valid); end
        checks++; if (fill !== 3'd0) begin errors++; $display("[TB] FAIL basic_pop_fill got %0d exp 0", fill); end
`ifdef HANDSHAKING_SLAVE_COUNT_EN
        checks++; if (rx_count !== 16'd1) begin errors++; $display("[TB] FAIL basic_rx_count got %0d exp 1", rx_count); end
`endif
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            data_in = 8'(k); data_valid = 1'b1;
            tick();
        end
        checks++; if (fill !== 3'd4) begin errors++; $display("[TB] FAIL full_fill got %0d exp 4", fill); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_data_ready got %b exp 0", data_ready); end
        data_in = 8'h05;
        tick(); tick();
        checks++; if (fill !== 3'd4) begin errors++; $display("[TB] FAIL stall_fill got %0d exp 4", fill); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("[TB] FAIL stall_head got %h exp 01", data_out); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_proto_err got %b exp 0", proto_err); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        tick();
        checks++; if (data_out !== 8'h02) begin errors++; $display("[TB] FAIL drain1_data_out got %h exp 02", data_out); end
        checks++; if (fill !== 3'd3) begin errors++; $display("[TB] FAIL drain1_fill got %0d exp 3", fill); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain1_data_ready got %b exp 1", data_ready); end
        tick();
        data_valid = 1'b0;
        checks++; if (fill !== 3'd3) begin errors++; $display("[TB] FAIL pending_accept_fill got %0d exp 3", fill); end
        checks++; if (data_out !== 8'h03) begin errors++; $display("[TB] FAIL drain2_data_out got %h exp 03", data_out); end
        tick();
        checks++; if (data_out !== 8'h04) begin errors++; $display("[TB] FAIL drain3_data_out got %h exp 04", data_out); end
        tick();
        checks++; if (data_out !== 8'h05) begin errors++; $display("[TB] FAIL drain4_data_out got %h exp 05", data_out); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %b exp 0", out_valid); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL drain_proto_err got %b exp 0", proto_err); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0; data_valid = 1'b1;
        data_in = 8'h10; tick();
        data_in = 8'h11; tick();
        checks++; if (fill !== 3'd2) begin errors++; $display("[TB] FAIL b2b_prefill got %0d exp 2", fill); end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = 8'h12 + 8'(k);
            checks++; if (data_out !== 8'h10 + 8'(k)) begin errors++; $display("[TB] FAIL b2b_order[%0d] got %h exp %h", k, data_out, 8'h10 + 8'(k)); end
            tick();
            checks++; if (fill !== 3'd2) begin errors++; $display("[TB] FAIL b2b_fill[%0d] got %0d exp 2", k, fill); end
        end
        data_valid = 1'b0;
        checks++; if (data_out !== 8'h1A) begin errors++; $display("[TB] FAIL b2b_tail0 got %h exp 1a", data_out); end
        tick();
        checks++; if (data_out !== 8'h1B) begin errors++; $display("[TB] FAIL b2b_tail1 got %h exp 1b", data_out); end
        tick();
        checks++; if (fill !== 3'd0) begin errors++; $display("[TB] FAIL b2b_empty got %0d exp 0", fill); end
    endtask

    task automatic test_proto_err();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = 8'hA0 + 8'(k); data_valid = 1'b1;
            tick();
        end
        data_in = 8'h96;
        tick();
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL perr_before got %b exp 0", proto_err); end
        data_in = 8'h69;
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL perr_set got %b exp 1", proto_err); end
        data_valid = 1'b0;
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL perr_sticky got %b exp 1", proto_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (data_out !== 8'hA1) begin errors++; $display("[TB] FAIL perr_pop_data got %h exp a1", data_out); end
        checks++; if (fill !== 3'd3) begin errors++; $display("[TB] FAIL perr_pop_fill got %0d exp 3", fill); end
`ifdef HANDSHAKING_SLAVE_COUNT_EN
        checks++; if (rx_count !== 16'd22) begin errors++; $display("[TB] FAIL perr_rx_count got %0d exp 22", rx_count); end
`endif
    endtask

    task automatic test_reset_mid();
        rst = 1'b0; data_valid = 1'b1; data_in = 8'h55; out_ready = 1'b1;
        tick();
        rst = 1'b1; data_valid = 1'b0; out_ready = 1'b0;
        checks++; if (fill !== 3'd0) begin errors++; $display("[TB] FAIL mid_fill got %0d exp 0", fill); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid got %b exp 0", out_valid); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_data_ready got %b exp 1", data_ready); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_data_out got %h exp 00", data_out); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_proto_err got %b exp 0", proto_err); end
`ifdef HANDSHAKING_SLAVE_COUNT_EN
        checks++; if (rx_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rx_count got %0d exp 0", rx_count); end
`endif
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_out_valid got %b exp 0", out_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL mid_after_data_out got %h exp 00", data_out); end
    endtask

    initial begin
        rst = 1'b0; data_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_drain();
        test_back_to_back();
        test_proto_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
